// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor. Computes
//                {bOut, Diff} = A - B - bIn one bit per clock, LSB first,
//                with a single full-subtractor cell and a borrow flip-flop.
//                A start/busy/done handshake lets several datapath FSMs
//                share one small subtract unit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   system clock, rising-edge
//    rst   in   synchronous reset, active-high
//    start in   request pulse, only looked at while idle
//    A     in   [N]  minuend, captured on accepted start
//    B     in   [N]  subtrahend, captured on accepted start
//    bIn   in   borrow-in, captured on accepted start
//    busy  out  high while an operation is in flight (SHIFT or DONE)
//    done  out  one-cycle pulse; Diff/bOut/ovf are valid from this cycle
//    Diff  out  [N]  A - B - bIn modulo 2^N
//    bOut  out  borrow-out, 1 iff A < B + bIn (unsigned)
//    ovf   out  two's-complement overflow flag
// ============================================================================
module serial_subtractor #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         bIn,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Diff,
    output logic         bOut,
    output logic         ovf
);

    localparam logic [1:0]    c_IDLE  = 2'd0;
    localparam logic [1:0]    c_SHIFT = 2'd1;
    localparam logic [1:0]    c_DONE  = 2'd2;
    localparam logic [CW-1:0] c_LAST  = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  ra_q,    ra_d;
    logic [N-1:0]  rb_q,    rb_d;
    logic [N-1:0]  res_q,   res_d;
    logic [N-1:0]  diff_q,  diff_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          br_q,    br_d;
    logic          sa_q,    sa_d;
    logic          sb_q,    sb_d;
    logic          bout_q,  bout_d;
    logic          ovf_q,   ovf_d;

    logic w_dbit;
    logic w_borrow;
    logic w_last;

    // Full-subtractor cell on the current LSBs and the running borrow.
    assign w_dbit   = ra_q[0] ^ rb_q[0] ^ br_q;
    assign w_borrow = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    // True on the N-th shift edge; the counter then reaches N.
    assign w_last   = (cnt_q == c_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (start) state_d = c_SHIFT;
            c_SHIFT: if (w_last) state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != c_IDLE);
        done = (state_q == c_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_q   <= '0;
            rb_q   <= '0;
            res_q  <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            res_q  <= res_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            br_q   <= br_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        res_d  = res_q;
        diff_d = diff_q;
        cnt_d  = cnt_q;
        br_d   = br_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    ra_d  = A;
                    rb_d  = B;
                    br_d  = bIn;
                    sa_d  = A[N-1];
                    sb_d  = B[N-1];
                    cnt_d = '0;
                end
            end
            c_SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                br_d  = w_borrow;
                res_d = {w_dbit, res_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                // The result is published on the last shift edge so that it
                // is already valid during the single DONE cycle. The final
                // difference bit w_dbit is also the result sign bit.
                if (w_last) begin
                    diff_d = {w_dbit, res_q[N-1:1]};
                    bout_d = w_borrow;
                    ovf_d  = (sa_q != sb_q) && (w_dbit != sa_q);
                end
            end
            default: ;
        endcase
    end

    assign Diff = diff_q;
    assign bOut = bout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire
